// File: rtl/uart_tx_feeder.sv
// Byte FIFO feeding a UART transmitter through its level-held Send/Busy handshake.
// Producers write single-cycle strobes. The FSM drains one byte per transmitter frame.
module uart_tx_feeder #(
  parameter int A  = 4,
  parameter int TO = 8
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic [7:0]   WrData,
  input  logic         WrEn,
  output logic         Full,
  output logic         Empty,
  output logic [A:0]   Level,
  output logic         Overflow,
  input  logic         ClrOverflow,
  output logic [7:0]   TxData,
  output logic         TxSend,
  input  logic         TxBusy,
  output logic         Timeout
);

  localparam int             DEPTH     = 1 << A;
  localparam logic [A:0]     LEVEL_MAX = {1'b1, {A{1'b0}}};
  localparam logic [TO-1:0]  TIMER_MAX = '1;

  typedef enum logic [1:0] {IDLE, REQ, HOLD, RELEASE} state_t;

  logic [7:0]    mem [DEPTH];
  logic [A-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [A:0]    level_reg, level_next;
  logic          full_reg, empty_reg, overflow_reg, overflow_next;
  state_t        state_reg, state_next;
  logic [7:0]    tx_data_reg, tx_data_next;
  logic          tx_send_reg, tx_send_next;
  logic          timeout_reg, timeout_next;
  logic [TO-1:0] timer_reg, timer_next, timer_inc;
  logic          push, pop;

  // A write against a full FIFO is dropped even if the FSM pops this cycle.
  assign push      = WrEn && !full_reg;
  assign timer_inc = timer_reg + 1'b1;

  always_ff @(posedge Clk) begin
    if (push)
      mem[wr_ptr_reg] <= WrData;
  end

  always_comb begin
    level_next = level_reg;
    if (push && !pop)
      level_next = level_reg + 1'b1;
    else if (!push && pop)
      level_next = level_reg - 1'b1;
  end

  always_comb begin
    overflow_next = overflow_reg;
    if (WrEn && full_reg)
      overflow_next = 1'b1;
    else if (ClrOverflow)
      overflow_next = 1'b0;
  end

  always_comb begin
    state_next   = state_reg;
    tx_data_next = tx_data_reg;
    tx_send_next = tx_send_reg;
    timer_next   = timer_reg;
    timeout_next = 1'b0;
    pop          = 1'b0;
    case (state_reg)
      IDLE: begin
        // Busy still high here (e.g. frame left over from before reset) blocks the pop.
        if (!empty_reg && !TxBusy) begin
          pop          = 1'b1;
          tx_data_next = mem[rd_ptr_reg];
          tx_send_next = 1'b1;
          timer_next   = '0;
          state_next   = REQ;
        end
      end
      REQ: begin
        if (TxBusy) begin
          state_next = HOLD;
        end else begin
          timer_next = timer_inc;
          // Abort on the edge the timer reaches its limit: Send is held 2^TO-1 cycles.
          if (timer_inc == TIMER_MAX) begin
            tx_send_next = 1'b0;
            timeout_next = 1'b1;
            state_next   = IDLE;
          end
        end
      end
      HOLD: begin
        tx_send_next = 1'b0;
        state_next   = RELEASE;
      end
      RELEASE: begin
        if (!TxBusy)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      full_reg     <= 1'b0;
      empty_reg    <= 1'b1;
      overflow_reg <= 1'b0;
      state_reg    <= IDLE;
      tx_data_reg  <= 8'h00;
      tx_send_reg  <= 1'b0;
      timeout_reg  <= 1'b0;
      timer_reg    <= '0;
    end else begin
      if (push)
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      level_reg    <= level_next;
      full_reg     <= (level_next == LEVEL_MAX);
      empty_reg    <= (level_next == '0);
      overflow_reg <= overflow_next;
      state_reg    <= state_next;
      tx_data_reg  <= tx_data_next;
      tx_send_reg  <= tx_send_next;
      timeout_reg  <= timeout_next;
      timer_reg    <= timer_next;
    end
  end

  assign Full     = full_reg;
  assign Empty    = empty_reg;
  assign Level    = level_reg;
  assign Overflow = overflow_reg;
  assign TxData   = tx_data_reg;
  assign TxSend   = tx_send_reg;
  assign Timeout  = timeout_reg;

endmodule
